// File: rtl/enc_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Package : enc_tx_scheduler_pkg
//  Purpose : Shared types for the PHY TX lane scheduler. Holds the encoder
//            comma/data select encoding, the scheduler state type and the
//            round-robin grant identity.
//  Rev     : 1.0  initial release
// ============================================================================
package enc_tx_scheduler_pkg;

  // Encoder word select: plain data or one of the control commas.
  typedef enum logic [2:0] {
    DATA_SEL           = 3'd0,
    START_PACKET_SEL   = 3'd1,
    END_PACKET_SEL     = 3'd2,
    ACK_SEL            = 3'd3,
    RESEND_PACKET0_SEL = 3'd4,
    RESEND_PACKET1_SEL = 3'd5,
    RESEND_PACKET2_SEL = 3'd6,
    RESEND_PACKET3_SEL = 3'd7
  } comma_sel_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CTRL  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    END   = 3'd4
  } tx_sched_state_t;

  // Identity of the requester that won the most recent contended grant.
  typedef enum logic {
    GRANT_CTRL = 1'b0,
    GRANT_PKT  = 1'b1
  } grant_t;

endpackage : enc_tx_scheduler_pkg
`default_nettype wire

// File: rtl/enc_tx_scheduler_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module  : tx_sched_rr_arb
//  Purpose : Two-requester round-robin arbiter (control vs. packet) used by
//            the TX scheduler while idle.
//  Ports   : clk, rst_n      clock / asynchronous active-low reset
//            en             arbitration allowed this cycle
//            ctrl_req       control comma pending
//            pkt_req        data packet pending
//            grant_ctrl     control requester wins (comb)
//            grant_pkt      packet requester wins (comb)
//  Rev     : 1.0  initial release
// ============================================================================
module tx_sched_rr_arb
  import enc_tx_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ctrl_req,
  input  logic pkt_req,
  output logic grant_ctrl,
  output logic grant_pkt
);

  grant_t last_grant;

  always_comb begin
    grant_ctrl = 1'b0;
    grant_pkt  = 1'b0;
    if (en) begin
      if (ctrl_req && pkt_req) begin
        // Contention: the side that did not win last time goes now.
        if (last_grant == GRANT_CTRL) begin
          grant_pkt = 1'b1;
        end else begin
          grant_ctrl = 1'b1;
        end
      end else if (ctrl_req) begin
        grant_ctrl = 1'b1;
      end else if (pkt_req) begin
        grant_pkt = 1'b1;
      end
    end
  end

  // Only contended grants move the round-robin pointer; an uncontended
  // grant leaves fairness history untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_CTRL;
    end else if (en && ctrl_req && pkt_req) begin
      last_grant <= grant_pkt ? GRANT_PKT : GRANT_CTRL;
    end
  end

endmodule : tx_sched_rr_arb
`default_nettype wire

// File: rtl/enc_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : enc_tx_scheduler
//  Purpose : Sequences the 8b/10b encoder wrapper on one PHY TX lane. Frames
//            each packet as START comma, N data flits, END comma, and inserts
//            ACK/RESEND control commas only between packets. At most one
//            encoder word per cycle, gated by serializer readiness.
//  Ports   : CLK, nRST          clock / asynchronous active-low reset
//            pkt_req/pkt_len    packet request and flit count
//            pkt_flit[_vld]     current data flit from the TX buffer
//            pkt_flit_pop       flit consumed this cycle (comb)
//            pkt_done           pulse with the END comma
//            ctrl_req/sel/meta  control comma request
//            ctrl_ack           pulse with the control comma
//            tx_ready           serializer accepts a word
//            enc_start/enc_comma_sel/enc_flit  encoder interface
//            busy               scheduler not idle
//  Rev     : 1.0  initial release
// ============================================================================
module enc_tx_scheduler
  import enc_tx_scheduler_pkg::*;
#(
  parameter  int PORTCOUNT     = 5,
  parameter  int MAX_PKT_FLITS = 16,
  localparam int LW            = $clog2(MAX_PKT_FLITS + 1),
  localparam int FW            = 8 * PORTCOUNT
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          pkt_req,
  input  logic [LW-1:0] pkt_len,
  input  logic [FW-1:0] pkt_flit,
  input  logic          pkt_flit_vld,
  output logic          pkt_flit_pop,
  output logic          pkt_done,
  input  logic          ctrl_req,
  input  comma_sel_t    ctrl_sel,
  input  logic [7:0]    ctrl_meta,
  output logic          ctrl_ack,
  input  logic          tx_ready,
  output logic          enc_start,
  output comma_sel_t    enc_comma_sel,
  output logic [FW-1:0] enc_flit,
  output logic          busy
);

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_FLITS);

  tx_sched_state_t state, state_nx;
  logic [LW-1:0]   cnt, cnt_nx;
  logic [LW-1:0]   len_q, len_nx;

  logic            issue;
  comma_sel_t      issue_sel;
  logic [FW-1:0]   issue_flit;
  logic            done_nx;
  logic            ack_nx;

  logic            arb_en;
  logic            grant_ctrl;
  logic            grant_pkt;

  assign arb_en       = (state == IDLE) && tx_ready;
  assign pkt_flit_pop = (state == DATA) && tx_ready && pkt_flit_vld;

  tx_sched_rr_arb u_arb (
    .clk        (CLK),
    .rst_n      (nRST),
    .en         (arb_en),
    .ctrl_req   (ctrl_req),
    .pkt_req    (pkt_req),
    .grant_ctrl (grant_ctrl),
    .grant_pkt  (grant_pkt)
  );

  // --------------------------------------------------------------------------
  // Next-state / issue logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    len_nx     = len_q;
    issue      = 1'b0;
    issue_sel  = DATA_SEL;
    issue_flit = '0;
    done_nx    = 1'b0;
    ack_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_ctrl) begin
          state_nx = CTRL;
        end else if (grant_pkt) begin
          state_nx = START;
          // Oversized lengths are clamped so the frame stays bounded.
          len_nx   = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
        end
      end

      CTRL: begin
        if (tx_ready) begin
          issue      = 1'b1;
          issue_sel  = ctrl_sel;
          issue_flit = FW'(ctrl_meta);
          ack_nx     = 1'b1;
          state_nx   = IDLE;
        end
      end

      START: begin
        if (tx_ready) begin
          issue     = 1'b1;
          issue_sel = START_PACKET_SEL;
          cnt_nx    = len_q;
          state_nx  = (len_q != '0) ? DATA : END;
        end
      end

      DATA: begin
        if (tx_ready && pkt_flit_vld) begin
          issue      = 1'b1;
          issue_sel  = DATA_SEL;
          issue_flit = pkt_flit;
          cnt_nx     = cnt - LW'(1);
          // Last flit of the packet: the counter is about to hit zero.
          if (cnt <= LW'(1)) begin
            state_nx = END;
          end
        end
      end

      END: begin
        if (tx_ready) begin
          issue     = 1'b1;
          issue_sel = END_PACKET_SEL;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. Select/flit hold when nothing is issued.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      enc_start     <= 1'b0;
      enc_comma_sel <= DATA_SEL;
      enc_flit      <= '0;
      pkt_done      <= 1'b0;
      ctrl_ack      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      len_q     <= len_nx;
      enc_start <= issue;
      if (issue) begin
        enc_comma_sel <= issue_sel;
        enc_flit      <= issue_flit;
      end
      pkt_done  <= done_nx;
      ctrl_ack  <= ack_nx;
      busy      <= (state_nx != IDLE);
    end
  end

endmodule : enc_tx_scheduler
`default_nettype wire

// File: tb/tb_enc_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_enc_tx_scheduler
//  Purpose : Directed self-checking bench for enc_tx_scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_enc_tx_scheduler;
  import enc_tx_scheduler_pkg::*;

  localparam int LW = 5;
  localparam int FW = 40;

  logic          CLK;
  logic          nRST;
  logic          pkt_req;
  logic [LW-1:0] pkt_len;
  logic [FW-1:0] pkt_flit;
  logic          pkt_flit_vld;
  logic          pkt_flit_pop;
  logic          pkt_done;
  logic          ctrl_req;
  comma_sel_t    ctrl_sel;
  logic [7:0]    ctrl_meta;
  logic          ctrl_ack;
  logic          tx_ready;
  logic          enc_start;
  comma_sel_t    enc_comma_sel;
  logic [FW-1:0] enc_flit;
  logic          busy;

  typedef struct {
    comma_sel_t    sel;
    logic [FW-1:0] flit;
    logic          done;
    logic          ack;
    int            cyc;
  } ev_t;

  ev_t           log_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [FW-1:0] flit_mem[16];
  int            flit_idx = 0;
  logic          last_pop = 1'b0;

  enc_tx_scheduler #(.PORTCOUNT(5), .MAX_PKT_FLITS(16)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .pkt_req      (pkt_req),
    .pkt_len      (pkt_len),
    .pkt_flit     (pkt_flit),
    .pkt_flit_vld (pkt_flit_vld),
    .pkt_flit_pop (pkt_flit_pop),
    .pkt_done     (pkt_done),
    .ctrl_req     (ctrl_req),
    .ctrl_sel     (ctrl_sel),
    .ctrl_meta    (ctrl_meta),
    .ctrl_ack     (ctrl_ack),
    .tx_ready     (tx_ready),
    .enc_start    (enc_start),
    .enc_comma_sel(enc_comma_sel),
    .enc_flit     (enc_flit),
    .busy         (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Records every issued encoder word with the cycle it appeared in.
  always @(negedge CLK) begin
    cyc++;
    if (nRST && enc_start)
      log_q.push_back('{sel: enc_comma_sel, flit: enc_flit, done: pkt_done,
                        ack: ctrl_ack, cyc: cyc});
  end

  // One clock cycle: drive inputs, sample the comb pop, advance the TX
  // buffer on pop, then behave like the requesters (drop on done/ack).
  task automatic tick(input logic rdy, input logic vld);
    tx_ready     = rdy;
    pkt_flit_vld = vld;
    pkt_flit     = flit_mem[flit_idx % 16];
    #1 last_pop  = pkt_flit_pop;
    @(posedge CLK);
    if (last_pop) flit_idx++;
    @(negedge CLK);
    #1;
    if (pkt_done) pkt_req = 1'b0;
    if (ctrl_ack) ctrl_req = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++)
      flit_mem[i] = {8'(8'hA0 + i), 32'hDEAD_BE00 | 32'(i)};
    flit_idx = 0;
  endtask

  task automatic test_reset();
    tx_ready = 1'b1; pkt_flit_vld = 1'b1;
    #1;
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL reset_enc_start: got %b expected 0", enc_start); end
    checks++; if (enc_comma_sel !== DATA_SEL) begin errors++; $display("FAIL reset_comma_sel: got %0d expected %0d", enc_comma_sel, DATA_SEL); end
    checks++; if (enc_flit !== '0) begin errors++; $display("FAIL reset_enc_flit: got %h expected 0", enc_flit); end
    checks++; if ({busy, pkt_done, ctrl_ack} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, pkt_done, ctrl_ack}); end
    checks++; if (pkt_flit_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", pkt_flit_pop); end
  endtask

  task automatic test_basic();
    comma_sel_t    exp_sel[5] = '{START_PACKET_SEL, DATA_SEL, DATA_SEL, DATA_SEL, END_PACKET_SEL};
    logic [FW-1:0] exp_flit[4];
    int            c0;
    exp_flit[0] = '0; exp_flit[1] = flit_mem[0]; exp_flit[2] = flit_mem[1]; exp_flit[3] = flit_mem[2];
    log_q.delete(); flit_idx = 0; c0 = cyc;
    pkt_len = 5'd3; pkt_req = 1'b1;
    repeat (8) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL basic_words: got %0d expected 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++; if (log_q[i].sel !== exp_sel[i]) begin errors++; $display("FAIL basic_sel[%0d]: got %0d expected %0d", i, log_q[i].sel, exp_sel[i]); end
      if (i < 4) begin
        checks++; if (log_q[i].flit !== exp_flit[i]) begin errors++; $display("FAIL basic_flit[%0d]: got %h expected %h", i, log_q[i].flit, exp_flit[i]); end
      end
      checks++; if (log_q[i].cyc != c0 + 2 + i) begin errors++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, log_q[i].cyc, c0 + 2 + i); end
      checks++; if (log_q[i].done !== (i == 4)) begin errors++; $display("FAIL basic_done[%0d]: got %b expected %b", i, log_q[i].done, (i == 4)); end
    end
    checks++; if (flit_idx != 3) begin errors++; $display("FAIL basic_pops: got %0d expected 3", flit_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_ctrl_wait();
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd4; pkt_req = 1'b1;
    repeat (3) tick(1'b1, 1'b1);
    ctrl_sel = ACK_SEL; ctrl_meta = 8'h5A; ctrl_req = 1'b1;
    repeat (10) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 7) begin errors++; $display("FAIL ctrlw_words: got %0d expected 7", log_q.size()); end
    if (log_q.size() == 7) begin
      checks++; if (log_q[5].sel !== END_PACKET_SEL) begin errors++; $display("FAIL ctrlw_end_sel: got %0d expected %0d", log_q[5].sel, END_PACKET_SEL); end
      checks++; if (log_q[6].sel !== ACK_SEL) begin errors++; $display("FAIL ctrlw_ack_sel: got %0d expected %0d", log_q[6].sel, ACK_SEL); end
      checks++; if (log_q[6].flit !== 40'h00_0000_005A) begin errors++; $display("FAIL ctrlw_meta: got %h expected 5a", log_q[6].flit); end
      checks++; if (log_q[6].ack !== 1'b1) begin errors++; $display("FAIL ctrlw_ack: got %b expected 1", log_q[6].ack); end
      checks++; if (log_q[6].cyc <= log_q[5].cyc) begin errors++; $display("FAIL ctrlw_order: got %0d expected > %0d", log_q[6].cyc, log_q[5].cyc); end
      for (int i = 0; i < 6; i++) begin
        checks++; if (log_q[i].ack !== 1'b0) begin errors++; $display("FAIL ctrlw_ack_early[%0d]: got %b expected 0", i, log_q[i].ack); end
      end
    end
    checks++; if (ctrl_ack !== 1'b0) begin errors++; $display("FAIL ctrlw_ack_pulse: got %b expected 0", ctrl_ack); end
  endtask

  task automatic test_round_robin();
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd1; pkt_req = 1'b1;
    ctrl_sel = RESEND_PACKET2_SEL; ctrl_meta = 8'h33; ctrl_req = 1'b1;
    repeat (8) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL rr1_words: got %0d expected 4", log_q.size()); end
    if (log_q.size() == 4) begin
      checks++; if (log_q[0].sel !== START_PACKET_SEL) begin errors++; $display("FAIL rr1_first: got %0d expected %0d", log_q[0].sel, START_PACKET_SEL); end
      checks++; if (log_q[1].flit !== flit_mem[0]) begin errors++; $display("FAIL rr1_flit: got %h expected %h", log_q[1].flit, flit_mem[0]); end
      checks++; if (log_q[3].sel !== RESEND_PACKET2_SEL) begin errors++; $display("FAIL rr1_ctrl: got %0d expected %0d", log_q[3].sel, RESEND_PACKET2_SEL); end
      checks++; if (log_q[3].flit !== 40'h33) begin errors++; $display("FAIL rr1_meta: got %h expected 33", log_q[3].flit); end
    end
    log_q.delete(); flit_idx = 0;
    pkt_req = 1'b1;
    ctrl_sel = RESEND_PACKET0_SEL; ctrl_meta = 8'hC3; ctrl_req = 1'b1;
    repeat (8) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL rr2_words: got %0d expected 4", log_q.size()); end
    if (log_q.size() == 4) begin
      checks++; if (log_q[0].sel !== RESEND_PACKET0_SEL) begin errors++; $display("FAIL rr2_first: got %0d expected %0d", log_q[0].sel, RESEND_PACKET0_SEL); end
      checks++; if (log_q[1].sel !== START_PACKET_SEL) begin errors++; $display("FAIL rr2_start: got %0d expected %0d", log_q[1].sel, START_PACKET_SEL); end
      checks++; if (log_q[3].done !== 1'b1) begin errors++; $display("FAIL rr2_done: got %b expected 1", log_q[3].done); end
    end
  endtask

  task automatic test_ready_stall();
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd4; pkt_req = 1'b1;
    repeat (3) tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      checks++; if (last_pop !== 1'b0) begin errors++; $display("FAIL rdy_stall_pop[%0d]: got %b expected 0", i, last_pop); end
      checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL rdy_stall_start[%0d]: got %b expected 0", i, enc_start); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rdy_stall_busy[%0d]: got %b expected 1", i, busy); end
    end
    repeat (8) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL rdy_words: got %0d expected 6", log_q.size()); end
    for (int i = 0; i < 4 && i + 1 < log_q.size(); i++) begin
      checks++; if (log_q[i + 1].flit !== flit_mem[i]) begin errors++; $display("FAIL rdy_order[%0d]: got %h expected %h", i, log_q[i + 1].flit, flit_mem[i]); end
    end
    checks++; if (flit_idx != 4) begin errors++; $display("FAIL rdy_pops: got %0d expected 4", flit_idx); end
  endtask

  task automatic test_vld_stall_len0();
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd3; pkt_req = 1'b1;
    repeat (3) tick(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      checks++; if (last_pop !== 1'b0) begin errors++; $display("FAIL vld_stall_pop[%0d]: got %b expected 0", i, last_pop); end
      checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL vld_stall_start[%0d]: got %b expected 0", i, enc_start); end
    end
    repeat (6) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL vld_words: got %0d expected 5", log_q.size()); end
    if (log_q.size() == 5) begin
      checks++; if (log_q[2].flit !== flit_mem[1]) begin errors++; $display("FAIL vld_flit1: got %h expected %h", log_q[2].flit, flit_mem[1]); end
      checks++; if (log_q[4].sel !== END_PACKET_SEL) begin errors++; $display("FAIL vld_end: got %0d expected %0d", log_q[4].sel, END_PACKET_SEL); end
    end
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd0; pkt_req = 1'b1;
    repeat (5) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL len0_words: got %0d expected 2", log_q.size()); end
    if (log_q.size() == 2) begin
      checks++; if (log_q[0].sel !== START_PACKET_SEL) begin errors++; $display("FAIL len0_start: got %0d expected %0d", log_q[0].sel, START_PACKET_SEL); end
      checks++; if (log_q[1].sel !== END_PACKET_SEL) begin errors++; $display("FAIL len0_end: got %0d expected %0d", log_q[1].sel, END_PACKET_SEL); end
      checks++; if (log_q[1].cyc != log_q[0].cyc + 1) begin errors++; $display("FAIL len0_b2b: got %0d expected %0d", log_q[1].cyc, log_q[0].cyc + 1); end
      checks++; if (log_q[1].done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", log_q[1].done); end
    end
    checks++; if (flit_idx != 0) begin errors++; $display("FAIL len0_pops: got %0d expected 0", flit_idx); end
  endtask

  task automatic test_len_clamp();
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd20; pkt_req = 1'b1;
    repeat (22) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 18) begin errors++; $display("FAIL clamp_words: got %0d expected 18", log_q.size()); end
    if (log_q.size() == 18) begin
      checks++; if (log_q[16].flit !== flit_mem[15]) begin errors++; $display("FAIL clamp_last_flit: got %h expected %h", log_q[16].flit, flit_mem[15]); end
      checks++; if (log_q[17].sel !== END_PACKET_SEL) begin errors++; $display("FAIL clamp_end: got %0d expected %0d", log_q[17].sel, END_PACKET_SEL); end
    end
    checks++; if (flit_idx != 16) begin errors++; $display("FAIL clamp_pops: got %0d expected 16", flit_idx); end
  endtask

  task automatic test_reset_mid();
    log_q.delete(); flit_idx = 0;
    pkt_len = 5'd4; pkt_req = 1'b1;
    repeat (4) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 3) begin errors++; $display("FAIL rmid_pre_words: got %0d expected 3", log_q.size()); end
    nRST = 1'b0;
    #1;
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL rmid_enc_start: got %b expected 0", enc_start); end
    checks++; if (enc_comma_sel !== DATA_SEL) begin errors++; $display("FAIL rmid_comma_sel: got %0d expected %0d", enc_comma_sel, DATA_SEL); end
    checks++; if (enc_flit !== '0) begin errors++; $display("FAIL rmid_enc_flit: got %h expected 0", enc_flit); end
    checks++; if ({busy, pkt_done, ctrl_ack, pkt_flit_pop} !== 4'b0000) begin errors++; $display("FAIL rmid_flags: got %b expected 0000", {busy, pkt_done, ctrl_ack, pkt_flit_pop}); end
    #1 nRST = 1'b1;
    @(negedge CLK); #1;
    log_q.delete(); flit_idx = 0;
    repeat (8) tick(1'b1, 1'b1);
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL rmid_words: got %0d expected 6", log_q.size()); end
    if (log_q.size() == 6) begin
      checks++; if (log_q[0].sel !== START_PACKET_SEL) begin errors++; $display("FAIL rmid_restart: got %0d expected %0d", log_q[0].sel, START_PACKET_SEL); end
      checks++; if (log_q[1].flit !== flit_mem[0]) begin errors++; $display("FAIL rmid_flit0: got %h expected %h", log_q[1].flit, flit_mem[0]); end
      checks++; if (log_q[5].sel !== END_PACKET_SEL) begin errors++; $display("FAIL rmid_end: got %0d expected %0d", log_q[5].sel, END_PACKET_SEL); end
    end
  endtask

  initial begin
    nRST = 1'b0; pkt_req = 1'b0; pkt_len = '0; pkt_flit = '0; pkt_flit_vld = 1'b0;
    ctrl_req = 1'b0; ctrl_sel = ACK_SEL; ctrl_meta = 8'h00; tx_ready = 1'b0;
    fill_mem();
    #12;
    test_reset();
    nRST = 1'b1;
    @(negedge CLK); #1;
    test_basic();
    test_ctrl_wait();
    test_round_robin();
    test_ready_stall();
    test_vld_stall_len0();
    test_len_clamp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_enc_tx_scheduler
`default_nettype wire
